// File: rtl/gfx_pkg.sv
// Shared graphics types: fragment layout, colour, framebuffer addressing
// and the saturating counter helper used by the depth tester.
package gfx_pkg;

    localparam int FB_ADDR_WIDTH = 17;
    localparam int COORD_WIDTH   = 17;
    localparam int COORD_FRAC    = 8;
    localparam int COORD_INT     = COORD_WIDTH - COORD_FRAC;

    typedef logic [11:0] color_t;

    // z is 0.17 fraction; x and y are 9.8 fixed point
    typedef struct packed {
        logic [COORD_WIDTH-1:0] z;
        logic [COORD_WIDTH-1:0] y;
        logic [COORD_WIDTH-1:0] x;
    } fragment_t;

    function automatic logic [COORD_INT-1:0] coord_int(input logic [COORD_WIDTH-1:0] c);
        return c[COORD_WIDTH-1:COORD_FRAC];
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, a} + {15'd0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/depth_ram.sv
// Simple dual-port depth buffer: one synchronous write port, one read port
// with a LAT-deep output register chain. Reads return pre-write data.
module depth_ram #(
    parameter int DEPTH = 76800,
    parameter int AW    = 17,
    parameter int DW    = 16,
    parameter int LAT   = 2
) (
    input  logic          clk_in,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem     [DEPTH];
    logic [DW-1:0] rd_pipe [LAT];

    always_ff @(posedge clk_in) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_pipe[0] <= mem[rd_addr];
        for (int i = 1; i < LAT; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    assign rd_data = rd_pipe[LAT-1];

endmodule

// File: rtl/depth_tester.sv
// Z-tests rasterizer fragments against an on-chip depth buffer and emits
// framebuffer writes for survivors; also sweeps both buffers on a clear.
module depth_tester
    import gfx_pkg::*;
#(
    parameter int          H_RES       = 320,
    parameter int          V_RES       = 240,
    parameter int          DEPTH_WIDTH = 16,
    parameter int          RAM_LATENCY = 2,
    parameter logic [11:0] CLEAR_COLOR = 12'h000
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             valid_in,
    input  logic [15:0]      triangle_id_in,
    input  logic [2:0][16:0] fragment_in,
    input  logic [11:0]      color_in,
    input  logic             clear_in,
    output logic             busy_out,
    output logic             clear_done_out,
    output logic             fb_valid_out,
    output logic [16:0]      fb_addr_out,
    output logic [11:0]      fb_data_out,
    output logic [15:0]      pass_count_out,
    output logic [15:0]      drop_count_out
);

    localparam int RL = RAM_LATENCY;
    localparam logic [FB_ADDR_WIDTH-1:0] LAST_ADDR = FB_ADDR_WIDTH'(H_RES * V_RES - 1);
    localparam logic [COORD_INT-1:0]     H_LIM     = COORD_INT'(H_RES);
    localparam logic [COORD_INT-1:0]     V_LIM     = COORD_INT'(V_RES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PENDING,
        ST_CLEARING
    } state_t;

    state_t state;
    logic [FB_ADDR_WIDTH-1:0] clr_addr;

    fragment_t                frag;
    logic [COORD_INT-1:0]     x_int;
    logic [COORD_INT-1:0]     y_int;
    logic [FB_ADDR_WIDTH-1:0] pix_addr;
    logic                     in_range;
    logic                     accept;
    logic                     drop0;
    logic                     unused_trace;

    assign frag         = fragment_t'(fragment_in);
    assign x_int        = coord_int(frag.x);
    assign y_int        = coord_int(frag.y);
    assign in_range     = (x_int < H_LIM) && (y_int < V_LIM);
    assign accept       = valid_in && (state == ST_IDLE) && !clear_in;
    assign drop0        = valid_in && !(accept && in_range);
    assign unused_trace = ^{triangle_id_in, frag};

    generate
        if (H_RES == 320) begin : g_addr_shift
            assign pix_addr = ({8'd0, y_int} << 8) + ({8'd0, y_int} << 6) + {8'd0, x_int};
        end else begin : g_addr_mul
            assign pix_addr = ({8'd0, y_int} * FB_ADDR_WIDTH'(H_RES)) + {8'd0, x_int};
        end
    endgenerate

    // Fragment pipeline: stage 0 issues the read, stage RL meets the read data
    logic [RL:0]              pipe_valid;
    logic [FB_ADDR_WIDTH-1:0] pipe_addr  [RL+1];
    logic [DEPTH_WIDTH-1:0]   pipe_z     [RL+1];
    color_t                   pipe_color [RL+1];

    // Recent pass writes the RAM read of the resolving fragment could not see
    logic [RL-1:0]            hist_valid;
    logic [FB_ADDR_WIDTH-1:0] hist_addr [RL];
    logic [DEPTH_WIDTH-1:0]   hist_z    [RL];

    logic [DEPTH_WIDTH-1:0]   ram_rd_data;
    logic [DEPTH_WIDTH-1:0]   stored_z;
    logic                     res_pass;
    logic                     res_fail;
    logic                     clearing;
    logic                     ram_we;
    logic [FB_ADDR_WIDTH-1:0] ram_wr_addr;
    logic [DEPTH_WIDTH-1:0]   ram_wr_data;

    always_comb begin
        stored_z = ram_rd_data;
        for (int i = RL - 1; i >= 0; i--) begin
            if (hist_valid[i] && (hist_addr[i] == pipe_addr[RL])) begin
                stored_z = hist_z[i];
            end
        end
    end

    assign res_pass    = pipe_valid[RL] && (pipe_z[RL] < stored_z);
    assign res_fail    = pipe_valid[RL] && !(pipe_z[RL] < stored_z);
    assign clearing    = (state == ST_CLEARING);
    assign ram_we      = clearing || res_pass;
    assign ram_wr_addr = clearing ? clr_addr : pipe_addr[RL];
    assign ram_wr_data = clearing ? '1 : pipe_z[RL];

    depth_ram #(
        .DEPTH (H_RES * V_RES),
        .AW    (FB_ADDR_WIDTH),
        .DW    (DEPTH_WIDTH),
        .LAT   (RL)
    ) u_depth_ram (
        .clk_in  (clk_in),
        .we      (ram_we),
        .wr_addr (ram_wr_addr),
        .wr_data (ram_wr_data),
        .rd_addr (pipe_addr[0]),
        .rd_data (ram_rd_data)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pipe_valid <= '0;
            hist_valid <= '0;
            for (int i = 0; i <= RL; i++) begin
                pipe_addr[i]  <= '0;
                pipe_z[i]     <= '0;
                pipe_color[i] <= '0;
            end
            for (int i = 0; i < RL; i++) begin
                hist_addr[i] <= '0;
                hist_z[i]    <= '0;
            end
        end else begin
            pipe_valid[0] <= accept && in_range;
            if (accept && in_range) begin
                pipe_addr[0]  <= pix_addr;
                pipe_z[0]     <= frag.z[COORD_WIDTH-1 -: DEPTH_WIDTH];
                pipe_color[0] <= color_in;
            end
            for (int i = 1; i <= RL; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_addr[i]  <= pipe_addr[i-1];
                pipe_z[i]     <= pipe_z[i-1];
                pipe_color[i] <= pipe_color[i-1];
            end
            hist_valid[0] <= res_pass;
            hist_addr[0]  <= pipe_addr[RL];
            hist_z[0]     <= pipe_z[RL];
            for (int i = 1; i < RL; i++) begin
                hist_valid[i] <= hist_valid[i-1];
                hist_addr[i]  <= hist_addr[i-1];
                hist_z[i]     <= hist_z[i-1];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state          <= ST_IDLE;
            clr_addr       <= '0;
            busy_out       <= 1'b0;
            clear_done_out <= 1'b0;
            fb_valid_out   <= 1'b0;
            fb_addr_out    <= '0;
            fb_data_out    <= '0;
            pass_count_out <= '0;
            drop_count_out <= '0;
        end else begin
            clear_done_out <= 1'b0;
            fb_valid_out   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (clear_in) begin
                        state    <= ST_PENDING;
                        busy_out <= 1'b1;
                    end
                end
                ST_PENDING: begin
                    if (pipe_valid == '0) begin
                        state    <= ST_CLEARING;
                        clr_addr <= '0;
                    end
                end
                ST_CLEARING: begin
                    fb_valid_out <= 1'b1;
                    fb_addr_out  <= clr_addr;
                    fb_data_out  <= CLEAR_COLOR;
                    if (clr_addr == LAST_ADDR) begin
                        state          <= ST_IDLE;
                        busy_out       <= 1'b0;
                        clear_done_out <= 1'b1;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            // Sweep never overlaps a resolve: Clearing starts only on an empty pipe
            if (res_pass) begin
                fb_valid_out <= 1'b1;
                fb_addr_out  <= pipe_addr[RL];
                fb_data_out  <= pipe_color[RL];
            end
            pass_count_out <= sat_add16(pass_count_out, {1'b0, res_pass});
            drop_count_out <= sat_add16(drop_count_out, {1'b0, drop0} + {1'b0, res_fail});
        end
    end

endmodule

// File: tb/tb_depth_tester.sv
// Directed bench for depth_tester: expected framebuffer writes are queued at
// issue time and a negedge monitor pops and compares each DUT write.
module tb_depth_tester;

    logic             clk_in = 1'b0;
    logic             rst_n_in;
    logic             valid_in;
    logic [15:0]      triangle_id_in;
    logic [2:0][16:0] fragment_in;
    logic [11:0]      color_in;
    logic             clear_in;
    logic             busy_out;
    logic             clear_done_out;
    logic             fb_valid_out;
    logic [16:0]      fb_addr_out;
    logic [11:0]      fb_data_out;
    logic [15:0]      pass_count_out;
    logic [15:0]      drop_count_out;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    logic [28:0] exp_q[$];
    int          exp_cyc_q[$];

    depth_tester dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .valid_in       (valid_in),
        .triangle_id_in (triangle_id_in),
        .fragment_in    (fragment_in),
        .color_in       (color_in),
        .clear_in       (clear_in),
        .busy_out       (busy_out),
        .clear_done_out (clear_done_out),
        .fb_valid_out   (fb_valid_out),
        .fb_addr_out    (fb_addr_out),
        .fb_data_out    (fb_data_out),
        .pass_count_out (pass_count_out),
        .drop_count_out (drop_count_out)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    initial begin
        #1500000;
        $display("FAIL watchdog: time limit reached, checks=%0d fails=%0d", checks, fails);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [16:0] fx(input int i);
        return {i[8:0], 8'h00};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic expect_write(input int addr, input logic [11:0] data, input int at_cyc);
        exp_q.push_back({addr[16:0], data});
        exp_cyc_q.push_back(at_cyc);
    endtask

    task automatic send(input logic [16:0] x, input logic [16:0] y, input logic [16:0] z,
                        input logic [11:0] c);
        fragment_in    = {z, y, x};
        color_in       = c;
        triangle_id_in = 16'($urandom_range(0, 65535));
        valid_in       = 1'b1;
        @(negedge clk_in);
        valid_in       = 1'b0;
    endtask

    task automatic check_counts(input int pass_exp, input int drop_exp);
        check("pass_count", {16'd0, pass_count_out}, pass_exp);
        check("drop_count", {16'd0, drop_count_out}, drop_exp);
    endtask

    // Monitor: every framebuffer write must match the head of the expected queue
    always @(negedge clk_in) begin
        if (rst_n_in && fb_valid_out) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_write: got addr %0d data %0h, expected no write", fb_addr_out, fb_data_out);
            end else begin
                logic [28:0] e;
                int          c;
                e = exp_q.pop_front();
                c = exp_cyc_q.pop_front();
                check("fb_addr", {15'd0, fb_addr_out}, {15'd0, e[28:12]});
                check("fb_data", {20'd0, fb_data_out}, {20'd0, e[11:0]});
                if (c >= 0) check("fb_latency", cyc, c);
            end
        end
    end

    initial begin
        bit found;
        rst_n_in       = 1'b0;
        valid_in       = 1'b0;
        clear_in       = 1'b0;
        triangle_id_in = '0;
        fragment_in    = '0;
        color_in       = '0;
        idle(3);
        check("rst_busy", busy_out, 0);
        check("rst_clear_done", clear_done_out, 0);
        check("rst_fb_valid", fb_valid_out, 0);
        check("rst_fb_addr", fb_addr_out, 0);
        check("rst_fb_data", fb_data_out, 0);
        check_counts(0, 0);
        rst_n_in = 1'b1;
        idle(2);

        // Full clear sweep
        for (int i = 0; i < 76800; i++) expect_write(i, 12'h000, -1);
        clear_in = 1'b1;
        @(negedge clk_in);
        clear_in = 1'b0;
        check("busy_after_clear", busy_out, 1);
        found = 0;
        for (int i = 0; i < 80000 && !found; i++) begin
            if (clear_done_out) found = 1;
            else @(negedge clk_in);
        end
        check("clear_done_seen", found, 1);
        #1;
        check("clear_writes_left", exp_q.size(), 0);
        check("busy_at_done", busy_out, 0);
        @(negedge clk_in);
        check("clear_done_pulse", clear_done_out, 0);
        check("busy_after_done", busy_out, 0);
        check_counts(0, 0);

        // Single fragment into cleared buffer: x=10, y=5 -> 5*320+10
        expect_write(1610, 12'hF00, cyc + 4);
        send(17'h00A80, 17'h00580, 17'h10000, 12'hF00);
        idle(6);
        check_counts(1, 0);

        // Farther fragment culled, nearer one ten cycles later written
        send(17'h00A80, 17'h00580, 17'h18000, 12'h0F0);
        idle(9);
        expect_write(1610, 12'h00F, cyc + 4);
        send(17'h00A80, 17'h00580, 17'h08000, 12'h00F);
        idle(6);
        check_counts(2, 1);

        // Back-to-back equal depth at (20,7): second must see the forwarded depth
        expect_write(2260, 12'h0F0, cyc + 4);
        send(fx(20), fx(7), 17'h10000, 12'h0F0);
        send(fx(20), fx(7), 17'h10000, 12'hABC);
        idle(6);
        check_counts(3, 2);

        // Equal depth two cycles apart at (30,8)
        expect_write(2590, 12'h123, cyc + 4);
        send(fx(30), fx(8), 17'h10000, 12'h123);
        idle(1);
        send(fx(30), fx(8), 17'h10000, 12'h456);
        idle(6);
        check_counts(4, 3);

        // 0.75, 0.25, 0.5 back-to-back at (40,9): last compares against newest (0.25)
        expect_write(2920, 12'h111, cyc + 4);
        send(fx(40), fx(9), 17'h18000, 12'h111);
        expect_write(2920, 12'h222, cyc + 4);
        send(fx(40), fx(9), 17'h08000, 12'h222);
        send(fx(40), fx(9), 17'h10000, 12'h333);
        idle(6);
        check_counts(6, 4);

        // Off-screen fragments dropped; last on-screen pixel accepted
        send(17'h14000, fx(5), 17'h00000, 12'hFFF);
        send(fx(0), fx(240), 17'h00000, 12'hFFF);
        expect_write(76799, 12'h5A5, cyc + 4);
        send(fx(319), fx(239), 17'h10000, 12'h5A5);
        idle(6);
        check_counts(7, 6);

        // Clear with a fragment in the same cycle and one during the sweep, then reset mid-sweep
        for (int i = 0; i < 1000; i++) expect_write(i, 12'h000, -1);
        clear_in = 1'b1;
        send(fx(50), fx(10), 17'h00000, 12'hEEE);
        clear_in = 1'b0;
        check("busy_second_clear", busy_out, 1);
        send(fx(60), fx(10), 17'h00000, 12'hDDD);
        found = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            if (fb_valid_out && fb_addr_out == 17'd999) found = 1;
            else @(negedge clk_in);
        end
        check("sweep_reached_999", found, 1);
        check_counts(7, 8);
        #2;
        rst_n_in = 1'b0;
        #1;
        check("abort_fb_valid", fb_valid_out, 0);
        check("abort_busy", busy_out, 0);
        check("abort_clear_done", clear_done_out, 0);
        check("abort_fb_addr", fb_addr_out, 0);
        check_counts(0, 0);
        check("abort_writes_left", exp_q.size(), 0);
        idle(3);
        check("reset_hold_fb_valid", fb_valid_out, 0);
        rst_n_in = 1'b1;
        idle(5);
        check("post_reset_busy", busy_out, 0);
        check_counts(0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
